// File: rtl/capp_pkg.sv
// Shared widths, FSM state type and the search-line encoder for the CAPP
// search controller.
package capp_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 100;
    localparam int IDX_W     = 7;
    localparam int LINE_W    = 2 * WORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2
    } state_e;

    // Line 2j fires on words storing 0 at bit j, line 2j+1 on words storing 1.
    function automatic logic [LINE_W-1:0] encode_search(input logic [WORD_W-1:0] key,
                                                        input logic [WORD_W-1:0] mask);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int j = 0; j < WORD_W; j++) begin
            l[2*j]   = mask[j] & key[j];
            l[2*j+1] = mask[j] & ~key[j];
        end
        return l;
    endfunction

endpackage

// File: rtl/capp_prio_enc.sv
// Combinational lowest-set-bit finder over the responder vector, plus a flag
// telling whether that bit is the only one set.
module capp_prio_enc
    import capp_pkg::*;
#(
    parameter int N  = NUM_WORDS,
    parameter int IW = IDX_W
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] index_o,
    output logic          found_o,
    output logic          single_o
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    always_comb begin
        index_o = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                index_o = IW'(i);
                found_o = 1'b1;
            end
        end
    end

    // v & (v-1) strips the lowest set bit; zero afterwards means it was alone.
    assign single_o = found_o && ((vec_i & (vec_i - ONE)) == '0);

endmodule

// File: rtl/capp_search_ctrl.sv
// Drives an encoded (key, mask) search onto the CAPP array, captures the
// per-word match flags and streams responding indices lowest-first.
module capp_search_ctrl
    import capp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_W-1:0]    cmd_key,
    input  logic [WORD_W-1:0]    cmd_mask,
    output logic [LINE_W-1:0]    mismatch_lines,
    input  logic [NUM_WORDS-1:0] match_lines,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDX_W-1:0]     rsp_index,
    output logic                 rsp_last,
    output logic                 rsp_none,
    output logic [IDX_W-1:0]     rsp_count
);

    localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [NUM_WORDS-1:0] ONE_HOT0    = {{(NUM_WORDS-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [NUM_WORDS-1:0] pending_q;
    logic [LINE_W-1:0]    lines_q;
    logic                 rsp_valid_q, rsp_last_q, rsp_none_q;
    logic [IDX_W-1:0]     rsp_index_q, rsp_count_q;

    logic [NUM_WORDS-1:0] enc_vec;
    logic [IDX_W-1:0]     enc_idx, cap_cnt;
    logic                 enc_found, enc_single;

    // One encoder serves both paths: raw capture in DRIVE, and the pending
    // set minus the beat currently on the bus in EMIT.
    assign enc_vec = (state_q == DRIVE) ? ~match_lines
                                        : (pending_q & ~(ONE_HOT0 << rsp_index_q));

    capp_prio_enc #(.N(NUM_WORDS), .IW(IDX_W)) u_prio (
        .vec_i    (enc_vec),
        .index_o  (enc_idx),
        .found_o  (enc_found),
        .single_o (enc_single)
    );

    always_comb begin
        cap_cnt = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            cap_cnt = cap_cnt + {{(IDX_W-1){1'b0}}, enc_vec[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= '0;
            lines_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_none_q  <= 1'b0;
            rsp_index_q <= '0;
            rsp_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        lines_q <= encode_search(cmd_key, cmd_mask);
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        pending_q   <= enc_vec;
                        rsp_count_q <= cap_cnt;
                        rsp_valid_q <= 1'b1;
                        rsp_index_q <= enc_idx;
                        rsp_last_q  <= enc_single | ~enc_found;
                        rsp_none_q  <= ~enc_found;
                        state_q     <= EMIT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                EMIT: begin
                    if (rsp_ready) begin
                        pending_q <= enc_vec;
                        if (rsp_last_q) begin
                            state_q     <= IDLE;
                            lines_q     <= '0;
                            rsp_valid_q <= 1'b0;
                            rsp_last_q  <= 1'b0;
                            rsp_none_q  <= 1'b0;
                            rsp_index_q <= '0;
                            rsp_count_q <= '0;
                        end else begin
                            rsp_index_q <= enc_idx;
                            rsp_last_q  <= enc_single;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign mismatch_lines = lines_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_index      = rsp_index_q;
    assign rsp_last       = rsp_last_q;
    assign rsp_none       = rsp_none_q;
    assign rsp_count      = rsp_count_q;

endmodule

// File: doc/capp_search_ctrl.md
Name: capp_search_ctrl

Overview:
- Search driver and response resolver for the CAPP cell array. It is the other end of the array's compare interface.
- Accepts a (key, mask) search command, encodes it onto the array's 64 mismatch lines and holds it for a settle window.
- Captures the array's per-word mismatch flags, then streams every responding word index (lowest first) to the consumer over a valid/ready handshake.
- Sits between the CAPP sequencer and the cell array.

Parameters:
- WORD_W, 32, bits per stored word; mismatch bus is 2*WORD_W.
- NUM_WORDS, 100, words in the array; width of match_lines.
- IDX_W, 7, index/count width; must satisfy 2**IDX_W > NUM_WORDS.
- SETTLE_CYCLES, 2, cycles mismatch lines are held before capture; legal range 1..15, 0 is illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  search command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_key  in  WORD_W  search key.
- cmd_mask  in  WORD_W  1 = compare this bit, 0 = don't care.
- mismatch_lines  out  2*WORD_W  to array; bit 2j+1 flags store bit j == 1, bit 2j flags store bit j == 0.
- match_lines  in  NUM_WORDS  from array; 1 = word mismatches, 0 = word responds.
- rsp_valid  out  1  responder beat valid.
- rsp_ready  in  1  consumer accepts beat.
- rsp_index  out  IDX_W  responding word index.
- rsp_last  out  1  final beat of this search.
- rsp_none  out  1  beat carries no index; search had zero responders.
- rsp_count  out  IDX_W  total responders latched at capture, valid while rsp_valid.

Behaviour:
- Reset (async, rst_n low): state=IDLE, mismatch_lines=0, rsp_valid=0, rsp_index=0, rsp_last=0, rsp_none=0, rsp_count=0, pending vector=0, settle counter=0.
- cmd_ready = (state==IDLE), combinational.
- Encoding, per bit j:
  - mask=0: lines 2j and 2j+1 both 0.
  - mask=1, key=1: line 2j=1, 2j+1=0.
  - mask=1, key=0: line 2j+1=1, 2j=0.
- States:
  - IDLE: mismatch_lines=0. On accept, register the encoded lines, load counter=SETTLE_CYCLES-1, go to DRIVE.
  - DRIVE: lines held constant. When counter==0: capture pending = ~match_lines, rsp_count = popcount(pending). Load the first beat, go to EMIT. Otherwise decrement the counter.
  - EMIT: outputs stable while rsp_valid && !rsp_ready. On handshake, clear the bit for rsp_index in pending and present the next lowest set bit next cycle. rsp_last=1 when exactly one pending bit remains. On handshake of the last beat, go to IDLE: rsp_valid=0 and mismatch_lines=0 after that edge.
  - Zero responders: a single beat with rsp_none=1, rsp_last=1, rsp_index=0, rsp_count=0.
- Latency: accept on edge E0. mismatch_lines is valid after E0. Capture occurs on edge E0+SETTLE_CYCLES; rsp_valid is high after that edge. Next command can be accepted the cycle after the last handshake.
- Back-to-back beats: one index per cycle when rsp_ready is held high. No bubbles between beats.
- Sampling: match_lines is sampled only on the capture edge. Changes during EMIT are ignored.
- cmd_valid outside IDLE: ignored, not accepted, not buffered.
- Reset mid-operation: immediate return to IDLE. mismatch_lines drops to 0 and the stream is abandoned with no rsp_last.
- All responders (NUM_WORDS=100): rsp_count=100, indices 0..99 emitted in order.

Decomposition:
- Package capp_pkg holds:
  - WORD_W, NUM_WORDS, IDX_W;
  - the state enum (IDLE, DRIVE, EMIT);
  - function encode_search(key, mask) returning 2*WORD_W lines.
- Sub-module capp_prio_enc: combinational lowest-set-bit finder. Inputs: the NUM_WORDS vector. Outputs: index[IDX_W], found, and single-bit-remaining flag. Used by both capture and EMIT.

Test Plan:
- Array model holds words 0..4 = 456, 457, 1000, 1000, 457 and words 5..99 = 0.
- Key=1, mask=1 -> mismatch_lines=64'h1; key=0, mask=1 -> 64'h2; mask=0 -> 64'h0. Check after E0 and held through DRIVE.
- Key=457, mask=FFFFFFFF, rsp_ready=1 -> beats 1, 4; rsp_last on 4; rsp_count=2. First rsp_valid after edge E0+2.
- Key=456, mask=FFFFFFFE -> beats 0, 1, 4, count=3. Then key=0, full mask -> indices 5..99 consecutive, count=95.
- Key=12345, full mask -> single beat with rsp_none=1, rsp_last=1, count=0. Return to IDLE and cmd_ready=1 the next cycle.
- Key=1000 with rsp_ready toggled 0,0,1,0,1 -> index 2 held stable across stalls, then 3 with last. Toggle match_lines during EMIT -> no change to the stream.
- Assert rst_n=0 mid-EMIT -> rsp_valid=0 and mismatch_lines=0 immediately. After release, cmd_ready=1 and a new search returns correct results.
